// File: rtl/fifo_pkg.sv
// Shared types and defaults for the FIFO burst writer.
// BURST_CSUM_EN adds the CSUM state used for the trailing checksum word.
package fifo_pkg;
  localparam int unsigned F_WIDTH_DEF   = 32;
  localparam int unsigned LEN_WIDTH_DEF = 8;

`ifdef BURST_CSUM_EN
  typedef enum logic [2:0] {IDLE, WRITE, CSUM, FLUSH, DONE} wr_state_t;
`else
  typedef enum logic [2:0] {IDLE, WRITE, FLUSH, DONE} wr_state_t;
`endif
endpackage

// File: rtl/burst_csum.sv
// Running XOR checksum over the payload words of one burst.
module burst_csum
  import fifo_pkg::*;
#(
  parameter int unsigned F_WIDTH = F_WIDTH_DEF
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               clear,
  input  logic               enable,
  input  logic [F_WIDTH-1:0] data,
  output logic [F_WIDTH-1:0] csum
);

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      csum <= '0;
    end else if (clear) begin
      csum <= '0;
    end else if (enable) begin
      csum <= csum ^ data;
    end
  end

endmodule

// File: rtl/fifo_burst_writer.sv
// Writes a burst of burst_len upstream words into a FIFO, honouring full and abort.
// Define BURST_CSUM_EN to append an XOR checksum word after the payload.
module fifo_burst_writer
  import fifo_pkg::*;
#(
  parameter int unsigned F_WIDTH   = F_WIDTH_DEF,
  parameter int unsigned LEN_WIDTH = LEN_WIDTH_DEF
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] burst_len,
  input  logic                 abort,
  input  logic                 src_valid,
  input  logic [F_WIDTH-1:0]   src_data,
  output logic                 src_ready,
  input  logic                 full,
  output logic                 insert,
  output logic [F_WIDTH-1:0]   wr_data,
  output logic                 flush,
  output logic                 busy,
  output logic                 done,
  output logic [LEN_WIDTH-1:0] words_sent
);

  wr_state_t            state;
  logic [LEN_WIDTH-1:0] len_q;
  logic                 pay_ins;
  logic                 last_word;

  // Payload write this cycle; abort wins over any insert
  assign pay_ins   = (state == WRITE) && src_valid && !full && !abort;
  // words_sent < len_q inside a burst, so the increment never wraps
  assign last_word = (words_sent + LEN_WIDTH'(1)) == len_q;

`ifdef BURST_CSUM_EN
  logic [F_WIDTH-1:0] csum;

  burst_csum #(.F_WIDTH(F_WIDTH)) u_csum (
    .clk_in (clk_in),
    .reset  (reset),
    .clear  ((state == IDLE) && start),
    .enable (pay_ins),
    .data   (src_data),
    .csum   (csum)
  );
`endif

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      len_q      <= '0;
      words_sent <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_q      <= burst_len;
            words_sent <= '0;
            state      <= (burst_len == '0) ? DONE : WRITE;
          end
        end
        WRITE: begin
          if (abort) begin
            state <= FLUSH;
          end else if (pay_ins) begin
            words_sent <= words_sent + LEN_WIDTH'(1);
            if (last_word) begin
`ifdef BURST_CSUM_EN
              state <= CSUM;
`else
              state <= DONE;
`endif
            end
          end
        end
`ifdef BURST_CSUM_EN
        CSUM: begin
          if (abort) begin
            state <= FLUSH;
          end else if (!full) begin
            state <= DONE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO-side handshake follows full/src_valid in the same cycle
  always_comb begin
    insert    = 1'b0;
    src_ready = 1'b0;
    wr_data   = '0;
    case (state)
      WRITE: begin
        src_ready = !full && !abort;
        insert    = pay_ins;
        wr_data   = src_data;
      end
`ifdef BURST_CSUM_EN
      CSUM: begin
        insert  = !full && !abort;
        wr_data = csum;
      end
`endif
      default: ;
    endcase
  end

  assign busy  = (state != IDLE);
  assign done  = (state == DONE);
  assign flush = (state == FLUSH);

endmodule

// File: tb/tb_fifo_burst_writer.sv
// Directed, table-driven bench for fifo_burst_writer (default widths).
module tb_fifo_burst_writer;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  burst_len;
  logic        abort;
  logic        src_valid;
  logic [31:0] src_data;
  logic        src_ready;
  logic        full;
  logic        insert;
  logic [31:0] wr_data;
  logic        flush;
  logic        busy;
  logic        done;
  logic [7:0]  words_sent;

  int n_cmp = 0;
  int n_bad = 0;

  fifo_burst_writer dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .start      (start),
    .burst_len  (burst_len),
    .abort      (abort),
    .src_valid  (src_valid),
    .src_data   (src_data),
    .src_ready  (src_ready),
    .full       (full),
    .insert     (insert),
    .wr_data    (wr_data),
    .flush      (flush),
    .busy       (busy),
    .done       (done),
    .words_sent (words_sent)
  );

  always #5 clk_in = ~clk_in;

  // ctl = {insert, src_ready, flush, busy, done}
  typedef struct {
    logic        st;
    logic [7:0]  len;
    logic        ab;
    logic        vl;
    logic [31:0] d;
    logic        fu;
    logic [4:0]  ctl;
    logic [31:0] wd;
    logic [7:0]  ws;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic st, input logic [7:0] len, input logic ab,
                     input logic vl, input logic [31:0] d, input logic fu,
                     input logic [4:0] ctl, input logic [31:0] wd, input logic [7:0] ws);
    vec_t v;
    v.st = st; v.len = len; v.ab = ab; v.vl = vl; v.d = d; v.fu = fu;
    v.ctl = ctl; v.wd = wd; v.ws = ws;
    vq.push_back(v);
  endtask

  function automatic logic [44:0] obs();
    return {insert, src_ready, flush, busy, done, wr_data, words_sent};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [7:0] len, input logic ab,
                       input logic vl, input logic [31:0] d, input logic fu);
    start = st; burst_len = len; abort = ab; src_valid = vl; src_data = d; full = fu;
  endtask

  initial begin
    int cnt;
    bit seen;

    drive(0, 8'd0, 0, 0, 32'h0, 0);
    reset = 1'b0;
    #12;
    check("reset_state", 64'(obs()), 64'(45'd0));
    @(negedge clk_in);
    reset = 1'b1;

    // Plain burst of four words
    add(0, 8'd0, 0, 0, 32'h00, 0, 5'b00000, 32'h00, 8'd0);
    add(1, 8'd4, 0, 0, 32'h00, 0, 5'b00000, 32'h00, 8'd0);
    add(0, 8'd0, 0, 1, 32'h11, 0, 5'b11010, 32'h11, 8'd0);
    add(0, 8'd0, 0, 1, 32'h22, 0, 5'b11010, 32'h22, 8'd1);
    add(0, 8'd0, 0, 1, 32'h33, 0, 5'b11010, 32'h33, 8'd2);
    add(0, 8'd0, 0, 1, 32'h44, 0, 5'b11010, 32'h44, 8'd3);
`ifdef BURST_CSUM_EN
    add(0, 8'd0, 0, 0, 32'h00, 0, 5'b10010, 32'h44, 8'd4);
`endif
    add(0, 8'd0, 0, 0, 32'h00, 0, 5'b00011, 32'h00, 8'd4);
    add(0, 8'd0, 1, 0, 32'h00, 0, 5'b00000, 32'h00, 8'd4);
    add(0, 8'd0, 0, 0, 32'h00, 0, 5'b00000, 32'h00, 8'd4);
    // Full stall of three cycles after the second word
    add(1, 8'd4, 0, 0, 32'h00, 0, 5'b00000, 32'h00, 8'd4);
    add(0, 8'd0, 0, 1, 32'h11, 0, 5'b11010, 32'h11, 8'd0);
    add(0, 8'd0, 0, 1, 32'h22, 0, 5'b11010, 32'h22, 8'd1);
    add(0, 8'd0, 0, 1, 32'h33, 1, 5'b00010, 32'h33, 8'd2);
    add(0, 8'd0, 0, 1, 32'h33, 1, 5'b00010, 32'h33, 8'd2);
    add(0, 8'd0, 0, 1, 32'h33, 1, 5'b00010, 32'h33, 8'd2);
    add(0, 8'd0, 0, 1, 32'h33, 0, 5'b11010, 32'h33, 8'd2);
    add(0, 8'd0, 0, 1, 32'h44, 0, 5'b11010, 32'h44, 8'd3);
`ifdef BURST_CSUM_EN
    add(0, 8'd0, 0, 0, 32'h00, 1, 5'b00010, 32'h44, 8'd4);
    add(0, 8'd0, 0, 0, 32'h00, 0, 5'b10010, 32'h44, 8'd4);
`endif
    // start and abort in DONE are both ignored
    add(1, 8'd2, 1, 0, 32'h00, 0, 5'b00011, 32'h00, 8'd4);
    add(0, 8'd0, 0, 0, 32'h00, 0, 5'b00000, 32'h00, 8'd4);
    add(0, 8'd0, 0, 0, 32'h00, 0, 5'b00000, 32'h00, 8'd4);
    // Zero-length burst
    add(1, 8'd0, 0, 0, 32'h00, 0, 5'b00000, 32'h00, 8'd4);
    add(0, 8'd0, 0, 1, 32'h55, 0, 5'b00011, 32'h00, 8'd0);
    add(0, 8'd0, 0, 0, 32'h00, 0, 5'b00000, 32'h00, 8'd0);
    // Abort after two words of an eight-word burst
    add(1, 8'd8, 0, 0, 32'h00, 0, 5'b00000, 32'h00, 8'd0);
    add(0, 8'd0, 0, 1, 32'h11, 0, 5'b11010, 32'h11, 8'd0);
    add(0, 8'd0, 0, 1, 32'h22, 0, 5'b11010, 32'h22, 8'd1);
    add(0, 8'd0, 1, 1, 32'h33, 0, 5'b00010, 32'h33, 8'd2);
    add(0, 8'd0, 0, 1, 32'h33, 0, 5'b00110, 32'h00, 8'd2);
    add(0, 8'd0, 0, 1, 32'h33, 0, 5'b00000, 32'h00, 8'd2);
`ifdef BURST_CSUM_EN
    // Abort while the checksum word is pending
    add(1, 8'd1, 0, 0, 32'h00, 0, 5'b00000, 32'h00, 8'd2);
    add(0, 8'd0, 0, 1, 32'h99, 0, 5'b11010, 32'h99, 8'd0);
    add(0, 8'd0, 1, 0, 32'h00, 0, 5'b00010, 32'h99, 8'd1);
    add(0, 8'd0, 0, 0, 32'h00, 0, 5'b00110, 32'h00, 8'd1);
    add(0, 8'd0, 0, 0, 32'h00, 0, 5'b00000, 32'h00, 8'd1);
`endif

    foreach (vq[i]) begin
      @(posedge clk_in); #1;
      drive(vq[i].st, vq[i].len, vq[i].ab, vq[i].vl, vq[i].d, vq[i].fu);
      @(negedge clk_in);
      check($sformatf("vec%0d", i), 64'(obs()), 64'({vq[i].ctl, vq[i].wd, vq[i].ws}));
    end

    // Maximum-length burst: no wrap, exactly 255 payload words
    @(posedge clk_in); #1;
    drive(1, 8'd255, 0, 0, 32'h0, 0);
    cnt = 0;
    seen = 0;
    for (int c = 0; c < 700 && !seen; c++) begin
      @(posedge clk_in); #1;
      drive(0, 8'd0, 0, 1, 32'(c), 0);
      @(negedge clk_in);
      if (insert) cnt++;
      if (done) begin
        seen = 1;
        check("maxlen_ws", 64'(words_sent), 64'd255);
      end
    end
    check("maxlen_done_seen", 64'(seen), 64'd1);
`ifdef BURST_CSUM_EN
    check("maxlen_inserts", 64'(cnt), 64'd256);
`else
    check("maxlen_inserts", 64'(cnt), 64'd255);
`endif

    // Reset in the middle of a burst at words_sent == 3
    @(posedge clk_in); #1;
    drive(1, 8'd8, 0, 0, 32'h0, 0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk_in); #1;
      drive(0, 8'd0, 0, 1, 32'hA0 + 32'(k), 0);
    end
    @(negedge clk_in);
    check("pre_reset", 64'({insert, busy, words_sent}), 64'({1'b1, 1'b1, 8'd3}));
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", 64'(obs()), 64'(45'd0));
    @(negedge clk_in); #1;
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_in);
      check($sformatf("post_reset_idle%0d", k), 64'(obs()), 64'(45'd0));
    end
    @(posedge clk_in); #1;
    drive(1, 8'd1, 0, 1, 32'hBEEF, 0);
    @(posedge clk_in); #1;
    drive(0, 8'd0, 0, 1, 32'hBEEF, 0);
    @(negedge clk_in);
    check("resume_insert", 64'({insert, wr_data}), 64'({1'b1, 32'hBEEF}));
`ifdef BURST_CSUM_EN
    @(posedge clk_in); #1;
    drive(0, 8'd0, 0, 0, 32'h0, 0);
    @(negedge clk_in);
    check("resume_csum", 64'({insert, wr_data}), 64'({1'b1, 32'hBEEF}));
`endif
    @(posedge clk_in); #1;
    drive(0, 8'd0, 0, 0, 32'h0, 0);
    @(negedge clk_in);
    check("resume_done", 64'({done, words_sent}), 64'({1'b1, 8'd1}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_burst_writer.md
FIFO_BURST_WRITER -- requirements
Module: fifo_burst_writer

Interface
REQ-001 Parameter F_WIDTH, default 32: data word width; matches the FIFO write port.
REQ-002 Parameter LEN_WIDTH, default 8: burst length counter width.
REQ-003 The block SHALL have an input clk_in (1 bit): write-side clock; all state updates on posedge.
REQ-004 The block SHALL have an input reset (1 bit): asynchronous, active-low reset.
REQ-005 The block SHALL have an input start (1 bit): burst request; sampled only in IDLE.
REQ-006 The block SHALL have an input burst_len (LEN_WIDTH bits): number of payload words; captured with start.
REQ-007 The block SHALL have an input abort (1 bit): terminate the current burst.
REQ-008 The block SHALL have an input src_valid (1 bit): upstream word available.
REQ-009 The block SHALL have an input src_data (F_WIDTH bits): upstream payload word.
REQ-010 The block SHALL have an output src_ready (1 bit): upstream word accepted this cycle when it is high together with src_valid.
REQ-011 The block SHALL have an input full (1 bit): FIFO full flag.
REQ-012 The block SHALL have an output insert (1 bit): FIFO write strobe.
REQ-013 The block SHALL have an output wr_data (F_WIDTH bits): FIFO write data.
REQ-014 The block SHALL have an output flush (1 bit): one-cycle FIFO flush pulse.
REQ-015 The block SHALL have an output busy (1 bit): high in every state except IDLE.
REQ-016 The block SHALL have an output done (1 bit): one-cycle pulse on burst completion.
REQ-017 The block SHALL have an output words_sent (LEN_WIDTH bits): payload words written in the current or last burst.

Function
REQ-018 FSM states SHALL be IDLE, WRITE, CSUM, FLUSH and DONE.
REQ-019 IDLE -> WRITE on start with burst_len!=0; burst_len is latched and words_sent is cleared.
REQ-020 start with burst_len==0 SHALL go IDLE -> DONE, with no insert.
REQ-021 In WRITE, src_ready SHALL equal !full, combinationally.
REQ-022 In WRITE, insert SHALL equal src_valid && !full, and wr_data SHALL equal src_data, in the same cycle.
REQ-023 insert SHALL never be high while full is high (overflow forbidden).
REQ-024 Each insert of a payload word SHALL increment words_sent by 1 at the clock edge.
REQ-025 When words_sent reaches the latched length, WRITE SHALL go to CSUM if BURST_CSUM_EN is defined, otherwise to DONE.
REQ-026 In CSUM, insert SHALL equal !full with wr_data = running checksum; on that insert the FSM SHALL go to DONE.
REQ-027 In CSUM, src_ready SHALL be 0.
REQ-028 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-029 abort in WRITE or CSUM SHALL take priority over insert: insert=0 and src_ready=0 that cycle, then the FSM goes to FLUSH.
REQ-030 FLUSH SHALL last one cycle with flush=1, then return to IDLE; done SHALL NOT pulse.
REQ-031 abort in IDLE or DONE SHALL be ignored.
REQ-032 start SHALL be ignored outside IDLE.
REQ-033 words_sent SHALL hold its value in IDLE until the next accepted start.
REQ-034 The length comparison SHALL be at full LEN_WIDTH; burst_len of 2^LEN_WIDTH-1 SHALL be legal, with no wrap inside a burst.

Reset
REQ-035 While reset is low, the FSM SHALL be IDLE, and insert, flush, done, busy and src_ready SHALL be 0.
REQ-036 While reset is low, wr_data, words_sent, the checksum and the latched length SHALL be 0.
REQ-037 Reset mid-burst SHALL abandon the burst immediately, with no flush pulse and no done pulse.

Configuration
REQ-038 Macro BURST_CSUM_EN defined: the checksum (XOR of all payload words of the burst) SHALL be cleared at start, accumulated on each payload insert, and written as one extra word after the payload via CSUM.
REQ-039 Macro BURST_CSUM_EN undefined: the CSUM state and the checksum register SHALL be absent; WRITE goes directly to DONE.

Structure
REQ-040 A shared package fifo_pkg SHALL hold the FSM state typedef (wr_state_t), F_WIDTH_DEF=32 and LEN_WIDTH_DEF=8.
REQ-041 Checksum logic SHALL be a sub-module, burst_csum (clear, enable, data in; checksum out), instantiated only under BURST_CSUM_EN.

Verification
REQ-042 Scenario: start, burst_len=4, src_valid held high, data 0x11,0x22,0x33,0x44, full=0 -> 4 consecutive inserts, words_sent=4, done pulses 1 cycle later (CSUM off).
REQ-043 Scenario: same as REQ-042 with BURST_CSUM_EN defined -> fifth insert with wr_data=0x44, then done.
REQ-044 Scenario: full forced high for 3 cycles after the 2nd word -> insert=0 and src_ready=0 for those 3 cycles, no word lost, total 4 inserts.
REQ-045 Scenario: abort asserted after the 2nd insert of a burst_len=8 burst -> no further insert, flush=1 for exactly 1 cycle, no done, busy drops, words_sent=2.
REQ-046 Scenario: reset pulled low mid-burst at words_sent=3 -> all outputs 0 asynchronously; after release, FSM is IDLE and start is required to resume.
REQ-047 Scenario: start with burst_len=0 -> no insert, done pulses 1 cycle after start.
